// File: rtl/pippo_wbmux_fwd_if.sv
// WB-stage bundle between the execution units, the GPR write port and the operand forwarding muxes.
interface pippo_wbmux_fwd_if #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4,
   parameter int SELW  = 2,
   parameter int AW    = 5
);
   logic                  wb_freeze;
   logic                  wb_flush;
   logic                  wb_valid;
   logic [SELW-1:0]       rfwb_op;
   logic [AW-1:0]         wb_rd;
   logic [NSRC*WIDTH-1:0] muxin;
   logic [WIDTH-1:0]      muxout;
   logic                  gpr_we;
   logic [AW-1:0]         gpr_waddr;
   logic [WIDTH-1:0]      muxreg;
   logic [AW-1:0]         fwd_a_addr;
   logic                  fwd_a_hit;
   logic [WIDTH-1:0]      fwd_a_data;
   logic [AW-1:0]         fwd_b_addr;
   logic                  fwd_b_hit;
   logic [WIDTH-1:0]      fwd_b_data;

   modport master (
      output wb_freeze, wb_flush, wb_valid, rfwb_op, wb_rd, muxin, fwd_a_addr, fwd_b_addr,
      input  muxout, gpr_we, gpr_waddr, muxreg, fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data
   );

   modport slave (
      input  wb_freeze, wb_flush, wb_valid, rfwb_op, wb_rd, muxin, fwd_a_addr, fwd_b_addr,
      output muxout, gpr_we, gpr_waddr, muxreg, fwd_a_hit, fwd_a_data, fwd_b_hit, fwd_b_data
   );
endinterface

// File: rtl/pippo_wbmux_fwd.sv
// Write-back source mux plus a short history of retired results that feeds the operand
// forwarding lookups (live WB stage first, then history newest to oldest).
module pippo_wbmux_fwd #(
   parameter int WIDTH = 32,
   parameter int NSRC  = 4,
   parameter int SELW  = 2,
   parameter int AW    = 5,
   parameter int DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   pippo_wbmux_fwd_if.slave  bus
);

   logic [WIDTH-1:0] muxout;
   logic             live_we;

   logic             v_q    [DEPTH];
   logic [AW-1:0]    rd_q   [DEPTH];
   logic [WIDTH-1:0] data_q [DEPTH];
   logic             v_d    [DEPTH];
   logic [AW-1:0]    rd_d   [DEPTH];
   logic [WIDTH-1:0] data_d [DEPTH];

   logic [WIDTH:0]   fwd_a;
   logic [WIDTH:0]   fwd_b;

   // Out-of-range selects give zero rather than aliasing onto a real source.
   always_comb begin
      muxout = '0;
      for (int k = 0; k < NSRC; k++) begin
         if (int'(bus.rfwb_op) == k) muxout = bus.muxin[k*WIDTH +: WIDTH];
      end
   end

   assign live_we = bus.wb_valid & ~bus.wb_freeze & ~bus.wb_flush & (bus.wb_rd != '0);

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         v_d[i]    = v_q[i];
         rd_d[i]   = rd_q[i];
         data_d[i] = data_q[i];
      end
      if (bus.wb_flush) begin
         for (int i = 0; i < DEPTH; i++) v_d[i] = 1'b0;
      end else if (!bus.wb_freeze) begin
         for (int i = 1; i < DEPTH; i++) begin
            v_d[i]    = v_q[i-1];
            rd_d[i]   = rd_q[i-1];
            data_d[i] = data_q[i-1];
         end
         v_d[0]    = bus.wb_valid & (bus.wb_rd != '0);
         rd_d[0]   = bus.wb_rd;
         data_d[0] = muxout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            v_q[i]    <= 1'b0;
            rd_q[i]   <= '0;
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            v_q[i]    <= v_d[i];
            rd_q[i]   <= rd_d[i];
            data_q[i] <= data_d[i];
         end
      end
   end

   // Scan oldest to newest so later matches override; x0 is never forwarded.
   function automatic logic [WIDTH:0] lookup(input logic [AW-1:0] addr);
      logic [WIDTH:0] r;
      r = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (v_q[i] && (rd_q[i] == addr)) r = {1'b1, data_q[i]};
      end
      if (live_we && (bus.wb_rd == addr)) r = {1'b1, muxout};
      if (addr == '0) r = '0;
      return r;
   endfunction

   always_comb begin
      fwd_a = lookup(bus.fwd_a_addr);
      fwd_b = lookup(bus.fwd_b_addr);
   end

   assign bus.muxout     = muxout;
   assign bus.gpr_we     = live_we;
   assign bus.gpr_waddr  = bus.wb_rd;
   assign bus.muxreg     = data_q[0];
   assign bus.fwd_a_hit  = fwd_a[WIDTH];
   assign bus.fwd_a_data = fwd_a[WIDTH-1:0];
   assign bus.fwd_b_hit  = fwd_b[WIDTH];
   assign bus.fwd_b_data = fwd_b[WIDTH-1:0];

endmodule

// File: tb/tb_pippo_wbmux_fwd.sv
// Directed bench for the WB mux / forwarding history: sel sweep, forwarding window,
// newest-wins, freeze, flush+freeze and asynchronous reset.
module tb_pippo_wbmux_fwd;

   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;

   pippo_wbmux_fwd_if #(.WIDTH(32), .NSRC(4), .SELW(2), .AW(5)) bus ();
   pippo_wbmux_fwd_if #(.WIDTH(32), .NSRC(3), .SELW(2), .AW(5)) bus3 ();

   pippo_wbmux_fwd #(.WIDTH(32), .NSRC(4), .SELW(2), .AW(5), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pippo_wbmux_fwd #(.WIDTH(32), .NSRC(3), .SELW(2), .AW(5), .DEPTH(2)) dut3 (
      .clk (clk),
      .rst (rst),
      .bus (bus3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive point: 1 time unit after the rising edge.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src0(input logic [31:0] val);
      bus.muxin[31:0] = val;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst = 1'b1;
      bus.wb_freeze = 1'b0; bus.wb_flush = 1'b0; bus.wb_valid = 1'b0;
      bus.rfwb_op = '0; bus.wb_rd = '0; bus.muxin = '0;
      bus.fwd_a_addr = 5'd5; bus.fwd_b_addr = 5'd7;
      bus3.wb_freeze = 1'b0; bus3.wb_flush = 1'b0; bus3.wb_valid = 1'b0;
      bus3.rfwb_op = '0; bus3.wb_rd = '0; bus3.muxin = '0;
      bus3.fwd_a_addr = '0; bus3.fwd_b_addr = '0;

      next_cycle();
      next_cycle();
      chk("rst_muxreg", bus.muxreg, 32'h0);
      chk("rst_a_hit", {31'd0, bus.fwd_a_hit}, 32'd0);
      chk("rst_a_data", bus.fwd_a_data, 32'h0);
      chk("rst_b_hit", {31'd0, bus.fwd_b_hit}, 32'd0);
      rst = 1'b0;

      // select sweep
      bus.muxin  = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      bus3.muxin = {32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
      for (int k = 0; k < 4; k++) begin
         bus.rfwb_op = 2'(k);
         bus3.rfwb_op = 2'(k);
         #1;
         chk($sformatf("sel%0d", k), bus.muxout, 32'h1000_0000 + 32'(k));
         chk($sformatf("sel3_%0d", k), bus3.muxout, (k == 3) ? 32'h0 : 32'h1000_0000 + 32'(k));
      end

      // forwarding window: live, two history cycles, then gone
      next_cycle();
      bus.rfwb_op = 2'd0; set_src0(32'h0000_AAAA);
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.fwd_a_addr = 5'd5;
      #1;
      chk("fwd_gpr_we", {31'd0, bus.gpr_we}, 32'd1);
      chk("fwd_waddr", {27'd0, bus.gpr_waddr}, 32'd5);
      chk("fwd_live_hit", {31'd0, bus.fwd_a_hit}, 32'd1);
      chk("fwd_live_data", bus.fwd_a_data, 32'h0000_AAAA);
      next_cycle();
      bus.wb_valid = 1'b0; set_src0(32'h0000_1234);
      #1;
      chk("fwd_h0_hit", {31'd0, bus.fwd_a_hit}, 32'd1);
      chk("fwd_h0_data", bus.fwd_a_data, 32'h0000_AAAA);
      chk("fwd_h0_muxreg", bus.muxreg, 32'h0000_AAAA);
      next_cycle();
      chk("fwd_h1_hit", {31'd0, bus.fwd_a_hit}, 32'd1);
      chk("fwd_h1_data", bus.fwd_a_data, 32'h0000_AAAA);
      chk("fwd_h1_muxreg", bus.muxreg, 32'h0000_1234);
      next_cycle();
      chk("fwd_gone_hit", {31'd0, bus.fwd_a_hit}, 32'd0);
      chk("fwd_gone_data", bus.fwd_a_data, 32'h0);

      // newest wins, x0 never written or forwarded
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; set_src0(32'h1); bus.fwd_b_addr = 5'd7;
      next_cycle();
      set_src0(32'h2);
      #1;
      chk("nw_live_data", bus.fwd_b_data, 32'h2);
      next_cycle();
      bus.wb_valid = 1'b0;
      #1;
      chk("nw_hist_hit", {31'd0, bus.fwd_b_hit}, 32'd1);
      chk("nw_hist_data", bus.fwd_b_data, 32'h2);
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.fwd_a_addr = 5'd0; bus.fwd_b_addr = 5'd0;
      #1;
      chk("x0_gpr_we", {31'd0, bus.gpr_we}, 32'd0);
      chk("x0_a_hit", {31'd0, bus.fwd_a_hit}, 32'd0);
      chk("x0_b_data", bus.fwd_b_data, 32'h0);

      // freeze: history holds, live stage never hits
      next_cycle();
      bus.wb_rd = 5'd3; set_src0(32'h9);
      next_cycle();
      bus.wb_freeze = 1'b1; bus.wb_rd = 5'd4; set_src0(32'h44);
      bus.fwd_a_addr = 5'd3; bus.fwd_b_addr = 5'd4;
      #1;
      chk("frz_gpr_we", {31'd0, bus.gpr_we}, 32'd0);
      for (int c = 0; c < 4; c++) begin
         next_cycle();
         chk($sformatf("frz%0d_a_data", c), bus.fwd_a_data, 32'h9);
         chk($sformatf("frz%0d_a_hit", c), {31'd0, bus.fwd_a_hit}, 32'd1);
         chk($sformatf("frz%0d_b_hit", c), {31'd0, bus.fwd_b_hit}, 32'd0);
         chk($sformatf("frz%0d_muxreg", c), bus.muxreg, 32'h9);
      end

      // flush while frozen: valids drop, data holds
      bus.wb_freeze = 1'b0; bus.wb_rd = 5'd10; set_src0(32'h10);
      next_cycle();
      bus.wb_valid = 1'b0; bus.wb_flush = 1'b1; bus.wb_freeze = 1'b1;
      bus.fwd_a_addr = 5'd10; bus.fwd_b_addr = 5'd3;
      #1;
      chk("fl_pre_a_data", bus.fwd_a_data, 32'h10);
      chk("fl_pre_b_data", bus.fwd_b_data, 32'h9);
      next_cycle();
      chk("fl_a_hit", {31'd0, bus.fwd_a_hit}, 32'd0);
      chk("fl_b_hit", {31'd0, bus.fwd_b_hit}, 32'd0);
      chk("fl_muxreg", bus.muxreg, 32'h10);
      bus.wb_flush = 1'b0; bus.wb_freeze = 1'b0;

      // asynchronous reset between edges
      bus.wb_valid = 1'b1; bus.wb_rd = 5'd6; set_src0(32'h66); bus.fwd_a_addr = 5'd6;
      next_cycle();
      bus.wb_valid = 1'b0;
      #1;
      chk("ar_pre_muxreg", bus.muxreg, 32'h66);
      chk("ar_pre_hit", {31'd0, bus.fwd_a_hit}, 32'd1);
      rst = 1'b1;
      #1;
      chk("ar_muxreg", bus.muxreg, 32'h0);
      chk("ar_hit", {31'd0, bus.fwd_a_hit}, 32'd0);
      chk("ar_data", bus.fwd_a_data, 32'h0);
      next_cycle();
      rst = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
